// File: rtl/data_cache_pkg.sv
// Shared types and geometry helpers for the direct-mapped write-through data cache.
package data_cache_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    WRITE  = 2'd2
  } state_e;

  typedef logic [3:0][7:0] word_t;

  function automatic int offset_w(input int words_per_line);
    return $clog2(words_per_line);
  endfunction

  function automatic int index_w(input int sets);
    return $clog2(sets);
  endfunction

  // Tag takes whatever is left above offset, index and the 2-bit byte offset.
  function automatic int tag_w(input int addr_width, input int sets, input int words_per_line);
    return addr_width - $clog2(sets) - $clog2(words_per_line) - 2;
  endfunction

endpackage

// File: rtl/data_cache_if.sv
// Single-word request/acknowledge bus between the cache (master) and main data memory (slave).
interface data_cache_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);

  logic                  mem_req_o;
  logic                  mem_we_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [DATA_WIDTH-1:0] mem_wdata_o;
  logic [DATA_WIDTH-1:0] mem_rdata_i;
  logic                  mem_ack_i;

  modport master (
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  mem_rdata_i, mem_ack_i
  );

  modport slave (
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output mem_rdata_i, mem_ack_i
  );

endinterface

// File: rtl/data_cache_array.sv
// Valid/tag/data storage: asynchronous read at index/offset, synchronous word and tag writes.
module data_cache_array
  import data_cache_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int SETS           = 16,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic                                   clk_i,
  input  logic                                   clr_i,
  input  logic [index_w(SETS)-1:0]               index_i,
  input  logic [offset_w(WORDS_PER_LINE)-1:0]    rd_offset_i,
  input  logic [offset_w(WORDS_PER_LINE)-1:0]    wr_offset_i,
  input  logic                                   word_we_i,
  input  logic [3:0][DATA_WIDTH/4-1:0]           wr_data_i,
  input  logic                                   tag_we_i,
  input  logic [tag_w(ADDR_WIDTH, SETS, WORDS_PER_LINE)-1:0] tag_i,
  output logic [3:0][DATA_WIDTH/4-1:0]           rd_data_o,
  output logic [tag_w(ADDR_WIDTH, SETS, WORDS_PER_LINE)-1:0] rd_tag_o,
  output logic                                   rd_valid_o
);

  localparam int TAG_W = tag_w(ADDR_WIDTH, SETS, WORDS_PER_LINE);

  logic [3:0][DATA_WIDTH/4-1:0] data_q  [SETS][WORDS_PER_LINE];
  logic [TAG_W-1:0]             tag_q   [SETS];
  logic [SETS-1:0]              valid_q;

  assign rd_data_o  = data_q[index_i][rd_offset_i];
  assign rd_tag_o   = tag_q[index_i];
  assign rd_valid_o = valid_q[index_i];

  // Word storage, written by refill data or by a store hit; not reset.
  always_ff @(posedge clk_i) begin
    if (word_we_i) begin
      data_q[index_i][wr_offset_i] <= wr_data_i;
    end
  end

  // Tag storage, written when the last word of a refill lands; not reset.
  always_ff @(posedge clk_i) begin
    if (tag_we_i) begin
      tag_q[index_i] <= tag_i;
    end
  end

  // Valid bits: clear wins over a same-cycle tag write so an aborted refill never validates.
  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      valid_q <= {SETS{1'b0}};
    end else if (tag_we_i) begin
      valid_q[index_i] <= 1'b1;
    end
  end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-allocate, write-through data cache: FSM, refill counter and memory bus drivers.
module data_cache
  import data_cache_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int SETS           = 16,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [ADDR_WIDTH-1:0]        addr_i,
  input  logic                         memRead_i,
  input  logic                         memWrite_i,
  input  logic [3:0][DATA_WIDTH/4-1:0] writeData_i,
  output logic [3:0][DATA_WIDTH/4-1:0] readData_o,
  output logic                         stall_o,
  data_cache_if.master                 mem
);

  localparam int OFFSET_W = offset_w(WORDS_PER_LINE);
  localparam int INDEX_W  = index_w(SETS);
  localparam int TAG_W    = tag_w(ADDR_WIDTH, SETS, WORDS_PER_LINE);
  localparam logic [OFFSET_W-1:0] LAST_WORD = OFFSET_W'(WORDS_PER_LINE - 1);

  state_e                state_q;
  logic [OFFSET_W-1:0]   refill_cnt_q;
  logic                  mem_req_q;
  logic                  mem_we_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_wdata_q;

  logic [OFFSET_W-1:0]   offset_s;
  logic [INDEX_W-1:0]    index_s;
  logic [TAG_W-1:0]      tag_s;
  logic [TAG_W-1:0]      rd_tag_s;
  logic                  rd_valid_s;
  logic                  access_s;
  logic                  hit_s;
  logic                  miss_s;
  logic                  write_hit_s;
  logic                  last_ack_s;
  logic                  unused_s;

  logic                         word_we_s;
  logic                         tag_we_s;
  logic [OFFSET_W-1:0]          wr_offset_s;
  logic [3:0][DATA_WIDTH/4-1:0] wr_word_s;

  assign offset_s = addr_i[OFFSET_W+1:2];
  assign index_s  = addr_i[OFFSET_W+2 +: INDEX_W];
  assign tag_s    = addr_i[ADDR_WIDTH-1 -: TAG_W];
  assign unused_s = ^addr_i[1:0];

  assign access_s    = memRead_i | memWrite_i;
  assign hit_s       = rd_valid_s & (rd_tag_s == tag_s);
  assign miss_s      = access_s & ~hit_s;
  assign write_hit_s = memWrite_i & hit_s;
  assign last_ack_s  = mem.mem_ack_i & (refill_cnt_q == LAST_WORD);

  data_cache_array #(
    .DATA_WIDTH     (DATA_WIDTH),
    .ADDR_WIDTH     (ADDR_WIDTH),
    .SETS           (SETS),
    .WORDS_PER_LINE (WORDS_PER_LINE)
  ) u_array (
    .clk_i       (clk_i),
    .clr_i       (rst_i),
    .index_i     (index_s),
    .rd_offset_i (offset_s),
    .wr_offset_i (wr_offset_s),
    .word_we_i   (word_we_s),
    .wr_data_i   (wr_word_s),
    .tag_we_i    (tag_we_s),
    .tag_i       (tag_s),
    .rd_data_o   (readData_o),
    .rd_tag_o    (rd_tag_s),
    .rd_valid_o  (rd_valid_s)
  );

  // Pipeline freeze: misses and store hits stall in IDLE; a write-through releases on its ack.
  always_comb begin
    stall_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (miss_s || write_hit_s) begin
          stall_o = 1'b1;
        end else begin
          stall_o = 1'b0;
        end
      end
      REFILL:  stall_o = 1'b1;
      WRITE:   stall_o = ~mem.mem_ack_i;
      default: stall_o = 1'b0;
    endcase
  end

  // Array write steering: refill data by counter, or the merged store word on a write hit.
  always_comb begin
    word_we_s   = 1'b0;
    tag_we_s    = 1'b0;
    wr_offset_s = offset_s;
    wr_word_s   = writeData_i;
    if (rst_i) begin
      word_we_s = 1'b0;
      tag_we_s  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          word_we_s = write_hit_s;
        end
        REFILL: begin
          word_we_s   = mem.mem_ack_i;
          tag_we_s    = last_ack_s;
          wr_offset_s = refill_cnt_q;
          wr_word_s   = mem.mem_rdata_i;
        end
        WRITE: begin
          word_we_s = 1'b0;
        end
        default: begin
          word_we_s = 1'b0;
          tag_we_s  = 1'b0;
        end
      endcase
    end
  end

  // Control FSM with registered bus outputs; refill walks words 0..WPL-1 back to back.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      refill_cnt_q <= {OFFSET_W{1'b0}};
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= {ADDR_WIDTH{1'b0}};
      mem_wdata_q  <= {DATA_WIDTH{1'b0}};
    end else begin
      case (state_q)
        IDLE: begin
          if (miss_s) begin
            state_q      <= REFILL;
            refill_cnt_q <= {OFFSET_W{1'b0}};
            mem_req_q    <= 1'b1;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= {tag_s, index_s, {OFFSET_W{1'b0}}, 2'b00};
          end else if (write_hit_s) begin
            state_q     <= WRITE;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b1;
            mem_addr_q  <= {addr_i[ADDR_WIDTH-1:2], 2'b00};
            mem_wdata_q <= writeData_i;
          end else begin
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
          end
        end
        REFILL: begin
          if (last_ack_s) begin
            state_q      <= IDLE;
            refill_cnt_q <= {OFFSET_W{1'b0}};
            mem_req_q    <= 1'b0;
          end else if (mem.mem_ack_i) begin
            refill_cnt_q <= refill_cnt_q + OFFSET_W'(1);
            mem_addr_q   <= {tag_s, index_s, refill_cnt_q + OFFSET_W'(1), 2'b00};
          end
        end
        WRITE: begin
          if (mem.mem_ack_i) begin
            state_q   <= IDLE;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
          end
        end
        default: begin
          state_q      <= IDLE;
          refill_cnt_q <= {OFFSET_W{1'b0}};
          mem_req_q    <= 1'b0;
          mem_we_q     <= 1'b0;
        end
      endcase
    end
  end

  assign mem.mem_req_o   = mem_req_q;
  assign mem.mem_we_o    = mem_we_q;
  assign mem.mem_addr_o  = mem_addr_q;
  assign mem.mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_data_cache.sv
// Table-driven bench for data_cache with a word memory model and a bus-transaction scoreboard.
module tb_data_cache;
  import data_cache_pkg::*;

  typedef struct {
    logic [31:0] addr;
    logic        rd;
    logic        wr;
    logic [31:0] wdata;
    logic        miss;
    int          lat;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } bus_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic        mem_read;
  logic        mem_write;
  word_t       wdata;
  word_t       rdata;
  logic        stall;

  logic [31:0] mem [16384];
  bus_t        exp_q[$];
  vec_t        vecs[14];
  int          n_cmp = 0;
  int          n_err = 0;
  int          lat = 2;
  int          wcnt = 0;
  int          acks = 0;

  data_cache_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) mif ();

  data_cache dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .addr_i      (addr),
    .memRead_i   (mem_read),
    .memWrite_i  (mem_write),
    .writeData_i (wdata),
    .readData_o  (rdata),
    .stall_o     (stall),
    .mem         (mif)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5EED, a[15:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_refill(input logic [31:0] a);
    logic [31:0] base;
    base = a & 32'hFFFF_FFF0;
    for (int w = 0; w < 4; w++) begin
      exp_q.push_back('{1'b0, base + 32'(4 * w), 32'h0});
    end
  endtask

  // One cycle: memory model decides ack at the negedge, then outputs are sampled.
  task automatic step();
    bus_t e;
    @(negedge clk);
    if (rst || !mif.mem_req_o) begin
      mif.mem_ack_i = 1'b0;
      wcnt = 0;
    end else if (wcnt == lat) begin
      mif.mem_ack_i = 1'b1;
      wcnt = 0;
      acks++;
      mif.mem_rdata_i = mem[mif.mem_addr_o[15:2]];
      if (mif.mem_we_o) mem[mif.mem_addr_o[15:2]] = mif.mem_wdata_o;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL bus_unexpected: got we=%0b addr=%h expected no request", mif.mem_we_o, mif.mem_addr_o);
      end else begin
        e = exp_q.pop_front();
        check("bus_we", {31'b0, mif.mem_we_o}, {31'b0, e.we});
        check("bus_addr", mif.mem_addr_o, e.addr);
        if (e.we) check("bus_wdata", mif.mem_wdata_o, e.wdata);
      end
    end else begin
      mif.mem_ack_i = 1'b0;
      wcnt++;
    end
    #1;
  endtask

  task automatic apply(input vec_t v, input int idx);
    int nst;
    int exp_st;
    lat = v.lat;
    @(posedge clk);
    #1;
    addr = v.addr;
    mem_read = v.rd;
    mem_write = v.wr;
    wdata = v.wdata;
    exp_st = 0;
    if (v.miss) begin
      push_refill(v.addr);
      exp_st = 4 * (lat + 1) + 1;
    end
    if (v.wr) begin
      exp_q.push_back('{1'b1, v.addr & 32'hFFFF_FFFC, v.wdata});
      exp_st += lat + 1;
    end
    nst = 0;
    step();
    while (stall && nst < 200) begin
      nst++;
      step();
    end
    check($sformatf("stall_cycles[%0d]", idx), 32'(nst), 32'(exp_st));
    if (!v.wr) begin
      check($sformatf("read_data[%0d]", idx), rdata, v.exp);
      check($sformatf("req_idle[%0d]", idx), {31'b0, mif.mem_req_o}, 32'h0);
    end
  endtask

  initial begin
    vec_t v;
    int   nst;
    int   n;
    for (int i = 0; i < 16384; i++) mem[i] = init_word(32'(i) << 2);
    rst = 1'b1;
    addr = 32'h0;
    mem_read = 1'b0;
    mem_write = 1'b0;
    wdata = 32'h0;
    mif.mem_ack_i = 1'b0;
    mif.mem_rdata_i = 32'h0;

    //            addr          rd    wr    wdata          miss  lat  expected read
    vecs[0]  = '{32'h0000_0100, 1'b1, 1'b0, 32'h0,         1'b1, 2, init_word(32'h100)};
    vecs[1]  = '{32'h0000_0104, 1'b1, 1'b0, 32'h0,         1'b0, 2, init_word(32'h104)};
    vecs[2]  = '{32'h0000_0108, 1'b0, 1'b1, 32'hDEADBEEF,  1'b0, 3, 32'h0};
    vecs[3]  = '{32'h0000_0108, 1'b1, 1'b0, 32'h0,         1'b0, 2, 32'hDEADBEEF};
    vecs[4]  = '{32'h0000_0900, 1'b1, 1'b0, 32'h0,         1'b1, 2, init_word(32'h900)};
    vecs[5]  = '{32'h0000_0100, 1'b1, 1'b0, 32'h0,         1'b1, 2, init_word(32'h100)};
    vecs[6]  = '{32'h0000_0108, 1'b1, 1'b0, 32'h0,         1'b0, 2, 32'hDEADBEEF};
    vecs[7]  = '{32'h0000_2004, 1'b0, 1'b1, 32'h12345678,  1'b1, 2, 32'h0};
    vecs[8]  = '{32'h0000_2004, 1'b1, 1'b0, 32'h0,         1'b0, 2, 32'h12345678};
    vecs[9]  = '{32'h0000_200C, 1'b1, 1'b0, 32'h0,         1'b0, 2, init_word(32'h200C)};
    vecs[10] = '{32'h0000_2008, 1'b1, 1'b1, 32'hAABBCCDD,  1'b0, 1, 32'h0};
    vecs[11] = '{32'h0000_2008, 1'b1, 1'b0, 32'h0,         1'b0, 1, 32'hAABBCCDD};
    vecs[12] = '{32'h0000_0154, 1'b1, 1'b0, 32'h0,         1'b1, 1, init_word(32'h154)};
    vecs[13] = '{32'h0000_7FF0, 1'b1, 1'b0, 32'h0,         1'b1, 0, init_word(32'h7FF0)};

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    step();
    check("rst_stall", {31'b0, stall}, 32'h0);
    check("rst_req", {31'b0, mif.mem_req_o}, 32'h0);
    check("rst_we", {31'b0, mif.mem_we_o}, 32'h0);
    check("rst_addr", mif.mem_addr_o, 32'h0);
    check("rst_wdata", mif.mem_wdata_o, 32'h0);

    for (int i = 0; i < 14; i++) apply(vecs[i], i);

    // Reset after the second refill ack of 0x300 abandons the line.
    lat = 2;
    @(posedge clk);
    #1;
    addr = 32'h300;
    mem_read = 1'b1;
    mem_write = 1'b0;
    push_refill(32'h300);
    acks = 0;
    n = 0;
    step();
    while (acks < 2 && n < 100) begin
      n++;
      step();
    end
    check("abort_acks", 32'(acks), 32'd2);
    @(posedge clk);
    #1;
    rst = 1'b1;
    step();
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    push_refill(32'h300);
    step();
    check("abort_req_low", {31'b0, mif.mem_req_o}, 32'h0);
    nst = 0;
    while (stall && nst < 200) begin
      nst++;
      step();
    end
    check("abort_refill_stall", 32'(nst), 32'd13);
    check("abort_refill_data", rdata, init_word(32'h300));

    // Valid bits were cleared by reset, so a previously cached line misses again.
    v = '{32'h0000_0154, 1'b1, 1'b0, 32'h0, 1'b1, 2, init_word(32'h154)};
    apply(v, 100);
    v = '{32'h0000_0158, 1'b1, 1'b0, 32'h0, 1'b0, 2, init_word(32'h158)};
    apply(v, 101);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
